// File: rtl/wb_burst_reader_if.sv
// Wishbone pipelined bus bundle shared by wb_burst_reader and its responders.
//   clk, rst : bus clock/reset, carried for responders; unused by the burst reader
//   master   : drives cyc, stb, we, sel, adr, dat_o; receives ack, err, stall, dat_i
//   slave    : the mirror image of master
interface wb_if (
  input logic clk,
  input logic rst
);
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic        ack;
  logic        err;
  logic        stall;

  modport master (
    output cyc, stb, we, sel, adr, dat_o,
    input  ack, err, stall, dat_i
  );

  modport slave (
    input  clk, rst, cyc, stb, we, sel, adr, dat_o,
    output ack, err, stall, dat_i
  );
endinterface

// File: rtl/wb_burst_reader.sv
// wb_burst_reader: Wishbone pipelined initiator that reads len_words consecutive 32-bit words
// from base_addr into an internal FIFO and presents them on a valid/ready stream.
//   clk, rst_n           : clock, asynchronous active-low reset
//   start                : command strobe, sampled only when idle
//   base_addr, len_words : first byte address (bits [1:0] ignored) and word count
//   busy, done, error    : command status; done is a 1-cycle pulse, error is sticky
//   m_data, m_valid,
//   m_ready              : read-data stream (FIFO head)
//   wb                   : Wishbone pipelined master port
// Optional build macro WB_BURST_READER_TIMEOUT_EN adds an ack watchdog of TIMEOUT_CYCLES.
module wb_burst_reader #(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned LEN_WIDTH      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [31:0]          base_addr,
  input  logic [LEN_WIDTH-1:0] len_words,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [31:0]          m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  wb_if.master                 wb
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e               state_q;
  logic                 busy_q, done_q, error_q, cyc_q, stb_q;
  logic [31:0]          adr_q;
  logic [LEN_WIDTH-1:0] issue_cnt_q, issue_cnt_d;
  logic [CW-1:0]        outst_q, outst_d;
  logic [CW-1:0]        fifo_cnt_q, fifo_cnt_d;
  logic [CW-1:0]        credit_d, credit_start;
  logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [31:0]          mem_q [FIFO_DEPTH];

  logic in_bus, issue, push, pop, abort, timeout;

  assign in_bus = (state_q == StReq) || (state_q == StWait);
  assign issue  = stb_q & ~wb.stall;
  assign abort  = in_bus & (wb.err | timeout);
  assign push   = in_bus & wb.ack & ~abort;
  assign pop    = m_valid & m_ready;

  // Credit is computed from post-edge occupancy so that a registered stb never requests a
  // word whose ack could find the FIFO full.
  assign fifo_cnt_d   = fifo_cnt_q + CW'(push) - CW'(pop);
  assign outst_d      = outst_q + CW'(issue) - CW'(push);
  assign issue_cnt_d  = issue_cnt_q - LEN_WIDTH'(issue);
  assign credit_d     = CW'(FIFO_DEPTH) - fifo_cnt_d - outst_d;
  assign credit_start = CW'(FIFO_DEPTH) - fifo_cnt_d;

`ifdef WB_BURST_READER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wdog_q;
  logic          wdog_run;

  assign wdog_run = cyc_q & (outst_q != '0) & ~wb.ack & ~wb.err;
  assign timeout  = wdog_run & (wdog_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q <= '0;
    end else if (wdog_run && !timeout) begin
      wdog_q <= wdog_q + 1'b1;
    end else begin
      wdog_q <= '0;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      adr_q       <= '0;
      issue_cnt_q <= '0;
      outst_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            adr_q       <= {base_addr[31:2], 2'b00};
            issue_cnt_q <= len_words;
            outst_q     <= '0;
            error_q     <= 1'b0;
            busy_q      <= 1'b1;
            if (len_words == '0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q <= StReq;
              cyc_q   <= 1'b1;
              stb_q   <= (credit_start != '0);
            end
          end
        end
        StReq, StWait: begin
          if (abort) begin
            error_q <= 1'b1;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            outst_q <= '0;
            state_q <= StDone;
            done_q  <= 1'b1;
          end else begin
            outst_q <= outst_d;
            if (state_q == StReq) begin
              if (issue) begin
                adr_q       <= adr_q + 32'd4;
                issue_cnt_q <= issue_cnt_d;
              end
              if (issue_cnt_d == '0) begin
                stb_q   <= 1'b0;
                state_q <= StWait;
              end else begin
                stb_q <= (credit_d != '0);
              end
            end else if (outst_d == '0) begin
              cyc_q   <= 1'b0;
              state_q <= StDone;
              done_q  <= 1'b1;
            end
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Read-data FIFO; acks are written the cycle they arrive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= wb.dat_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign error   = error_q;
  assign m_valid = (fifo_cnt_q != '0);
  assign m_data  = mem_q[rd_ptr_q];

  assign wb.cyc   = cyc_q;
  assign wb.stb   = stb_q;
  assign wb.we    = 1'b0;
  assign wb.sel   = 4'hF;
  assign wb.adr   = adr_q;
  assign wb.dat_o = '0;

endmodule

// File: tb/tb_wb_burst_reader.sv
// Self-checking bench for wb_burst_reader with a randomized pipelined responder.
module tb_wb_burst_reader;
  localparam int Depth = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_rst;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] len_words;
  logic        busy, done, error;
  logic [31:0] m_data;
  logic        m_valid, m_ready;

  always #5 clk = ~clk;
  assign wb_rst = ~rst_n;

  wb_if wb (.clk(clk), .rst(wb_rst));

  wb_burst_reader dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .base_addr(base_addr),
    .len_words(len_words),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .wb       (wb)
  );

  typedef struct {
    logic [31:0] adr;
    int          due;
  } req_t;

  int checks = 0;
  int errors = 0;

  // Responder / monitor state
  req_t        pend[$];
  logic [31:0] got_q[$];
  logic [31:0] adr_log[$];
  int          adr_cyc[$];
  int cyc_n = 0, last_due = 0;
  int done_cnt = 0, ack_cnt = 0, acked = 0, popped = 0;
  int err_at = 0, stall_mode = 0, max_delay = 1, no_ack = 0;
  int ready_mode = 0;
  logic ready_val = 1'b0;
  int hold_viol = 0, max_occ = 0, cyc_seen = 0;
  int first_ack_cyc = -1, first_valid_cyc = -1, err_cyc = -10;
  logic cyc_after_err = 1'b1;
  logic held_valid = 1'b0;
  logic [31:0] held_adr = '0;

  // Responder memory contents: distinct for every word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5AC3, ~a[31:16]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic launch(input logic [31:0] base, input logic [15:0] len);
    ack_cnt = 0; done_cnt = 0; hold_viol = 0; max_occ = 0; cyc_seen = 0;
    first_ack_cyc = -1; first_valid_cyc = -1; err_cyc = -10; cyc_after_err = 1'b1;
    got_q.delete(); adr_log.delete(); adr_cyc.delete();
    start = 1'b1; base_addr = base; len_words = len;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'(busy), 32'd0);
  endtask

  task automatic drain(input int n);
    int k = 0;
    while (got_q.size() < n && k < 1000) begin
      tick();
      k++;
    end
    repeat (3) tick();
  endtask

  task automatic check_stream(input logic [31:0] base, input int len, input string tag);
    logic [31:0] al;
    al = {base[31:2], 2'b00};
    check({tag, " word count"}, 32'(got_q.size()), 32'(len));
    for (int i = 0; i < len && i < got_q.size(); i++)
      check({tag, " word"}, got_q[i], mem_word(al + 32'(4 * i)));
  endtask

  task automatic check_adrs(input logic [31:0] base, input int len, input string tag);
    logic [31:0] al;
    al = {base[31:2], 2'b00};
    check({tag, " issue count"}, 32'(adr_log.size()), 32'(len));
    for (int i = 0; i < len && i < adr_log.size(); i++)
      check({tag, " adr"}, adr_log[i], al + 32'(4 * i));
  endtask

  // Responder and stream consumer, acting at the falling edge so the DUT samples settled inputs.
  initial begin
    int d;
    int occ;
    wb.ack = 1'b0; wb.err = 1'b0; wb.stall = 1'b0; wb.dat_i = '0;
    m_ready = 1'b0;
    forever begin
      @(negedge clk);
      cyc_n++;
      m_ready = (ready_mode != 0) ? 1'($urandom_range(0, 1)) : ready_val;
      if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc_n;
      if (m_valid && m_ready) begin
        got_q.push_back(m_data);
        popped++;
      end
      if (done) done_cnt++;
      if (wb.cyc) cyc_seen = 1;
      if (cyc_n == err_cyc + 1) cyc_after_err = wb.cyc;
      wb.ack = 1'b0;
      wb.err = 1'b0;
      if (!wb.cyc) begin
        pend.delete();
        wb.stall = 1'b0;
        held_valid = 1'b0;
      end else begin
        if (held_valid && (!wb.stb || wb.adr !== held_adr)) hold_viol++;
        case (stall_mode)
          1:       wb.stall = (cyc_n % 2 == 0);
          default: wb.stall = 1'b0;
        endcase
        if (wb.stb && !wb.stall) begin
          d = cyc_n + int'($urandom_range(1, max_delay));
          if (d <= last_due) d = last_due + 1;
          last_due = d;
          pend.push_back('{adr: wb.adr, due: d});
          adr_log.push_back(wb.adr);
          adr_cyc.push_back(cyc_n);
        end
        held_valid = wb.stb && wb.stall;
        held_adr = wb.adr;
        if (no_ack == 0 && pend.size() > 0 && pend[0].due <= cyc_n) begin
          ack_cnt++;
          if (ack_cnt == err_at) begin
            wb.err = 1'b1;
            err_cyc = cyc_n;
            pend.delete();
          end else begin
            wb.ack = 1'b1;
            wb.dat_i = mem_word(pend[0].adr);
            void'(pend.pop_front());
            acked++;
            if (first_ack_cyc < 0) first_ack_cyc = cyc_n;
          end
        end
      end
      occ = pend.size() + acked - popped;
      if (occ > max_occ) max_occ = occ;
    end
  end

  initial begin
    #3000000;
    $display("FAIL global time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] b;
    int l;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; len_words = '0;
    repeat (3) tick();
    check("reset busy", 32'(busy), 0);
    check("reset done", 32'(done), 0);
    check("reset error", 32'(error), 0);
    check("reset m_valid", 32'(m_valid), 0);
    check("reset cyc", 32'(wb.cyc), 0);
    check("reset stb", 32'(wb.stb), 0);
    check("reset adr", wb.adr, 0);
    check("bus we", 32'(wb.we), 0);
    check("bus sel", 32'(wb.sel), 32'hF);
    rst_n = 1'b1;
    tick();

    // Basic 4-word burst, zero-wait responder
    ready_val = 1'b1;
    launch(32'h100, 16'd4);
    wait_idle(100, "t1 completes");
    drain(4);
    check_adrs(32'h100, 4, "t1");
    for (int i = 0; i < adr_cyc.size(); i++)
      check("t1 issue spacing", 32'(adr_cyc[i] - adr_cyc[0]), 32'(i));
    check_stream(32'h100, 4, "t1");
    check("t1 done pulses", 32'(done_cnt), 1);
    check("t1 error", 32'(error), 0);
    check("t1 cyc idle", 32'(wb.cyc), 0);
    check("t1 ack to valid latency", 32'(first_valid_cyc - first_ack_cyc), 1);

    // Backpressure: only FIFO_DEPTH requests may be in flight
    ready_val = 1'b0;
    launch(32'h2000, 16'd16);
    repeat (40) tick();
    check("t2 issued before drain", 32'(adr_log.size()), Depth);
    check("t2 stb low", 32'(wb.stb), 0);
    check("t2 busy", 32'(busy), 1);
    check("t2 cyc held", 32'(wb.cyc), 1);
    ready_val = 1'b1;
    wait_idle(300, "t2 completes");
    drain(16);
    check_stream(32'h2000, 16, "t2");
    check("t2 occupancy bound", 32'(max_occ > Depth), 0);

    // Stall every other cycle, random ack delay and random consumer
    stall_mode = 1; max_delay = 3; ready_mode = 1;
    for (int it = 0; it < 5; it++) begin
      b = $urandom;
      l = int'($urandom_range(1, 30));
      launch(b, 16'(l));
      wait_idle(2000, "t3 completes");
      drain(l);
      check_adrs(b, l, "t3");
      check_stream(b, l, "t3");
      check("t3 done pulses", 32'(done_cnt), 1);
      check("t3 error", 32'(error), 0);
      check("t3 adr hold", 32'(hold_viol), 0);
      check("t3 occupancy bound", 32'(max_occ > Depth), 0);
    end
    stall_mode = 0; max_delay = 1; ready_mode = 0; ready_val = 1'b1;
    repeat (5) tick();

    // err on the third ack
    err_at = 3;
    launch(32'h300, 16'd6);
    wait_idle(100, "t4 completes");
    drain(2);
    check("t4 error", 32'(error), 1);
    check("t4 cyc after err", 32'(cyc_after_err), 0);
    check("t4 done pulses", 32'(done_cnt), 1);
    check_stream(32'h300, 2, "t4");
    err_at = 0;
    launch(32'h400, 16'd2);
    check("t4 error cleared", 32'(error), 0);
    check("t4 busy", 32'(busy), 1);
    wait_idle(100, "t4b completes");
    drain(2);
    check_stream(32'h400, 2, "t4b");

    // Address wrap with ignored low bits
    launch(32'hFFFF_FFFA, 16'd4);
    wait_idle(100, "t5 completes");
    drain(4);
    check_adrs(32'hFFFF_FFF8, 4, "t5");
    check_stream(32'hFFFF_FFF8, 4, "t5");

    // Zero-length command
    launch(32'h500, 16'd0);
    wait_idle(20, "t5 len0 completes");
    repeat (2) tick();
    check("t5 len0 done pulses", 32'(done_cnt), 1);
    check("t5 len0 no cyc", 32'(cyc_seen), 0);

    // start while busy is ignored
    ready_val = 1'b0;
    launch(32'h600, 16'd8);
    repeat (3) tick();
    start = 1'b1; base_addr = 32'h700; len_words = 16'd2;
    tick();
    start = 1'b0;
    ready_val = 1'b1;
    wait_idle(200, "t5 busy completes");
    drain(8);
    repeat (5) tick();
    check("t5 ignored start done", 32'(done_cnt), 1);
    check("t5 ignored start busy", 32'(busy), 0);
    check_adrs(32'h600, 8, "t5 busy");
    check_stream(32'h600, 8, "t5 busy");

    // Asynchronous reset mid-burst
    ready_val = 1'b0;
    launch(32'h800, 16'd20);
    repeat (5) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("t6 busy", 32'(busy), 0);
    check("t6 cyc", 32'(wb.cyc), 0);
    check("t6 stb", 32'(wb.stb), 0);
    check("t6 m_valid", 32'(m_valid), 0);
    check("t6 adr", wb.adr, 0);
    check("t6 error", 32'(error), 0);
    acked = 0; popped = 0;
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    check("t6 fifo empty", 32'(m_valid), 0);
    check("t6 idle", 32'(busy), 0);

`ifdef WB_BURST_READER_TIMEOUT_EN
    ready_val = 1'b1;
    no_ack = 1;
    launch(32'h900, 16'd1);
    wait_idle(1200, "t6 timeout completes");
    check("t6 timeout error", 32'(error), 1);
    check("t6 timeout done", 32'(done_cnt), 1);
    no_ack = 0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
